temp_average_divider: RTL and testbench

Sequential consumer of the sensor-aggregation outputs: the running temperature sum and the active-sensor count. On a start pulse it computes the rounded average temperature with a radix-2 restoring divider, one quotient bit per cycle. It then classifies the average against low/high thresholds and presents the result with a one-cycle valid strobe. It sits between the sensor aggregation stage and the display/alarm logic.

---
 rtl/temp_monitor_pkg.sv | 16 +
 rtl/temp_average_divider_if.sv | 28 ++
 rtl/seq_divider_core.sv | 63 ++++++
 rtl/temp_average_divider.sv | 118 +++++++++++
 tb/tb_temp_average_divider.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/temp_monitor_pkg.sv
// Shared defaults and types for the temperature monitoring datapath.
package temp_monitor_pkg;
  localparam int unsigned SUM_W_DEF     = 16;
  localparam int unsigned CNT_W_DEF     = 8;
  localparam int unsigned TEMP_LOW_DEF  = 19;
  localparam int unsigned TEMP_HIGH_DEF = 26;

  localparam logic [7:0] AVG_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    ROUND  = 2'd2,
    DONE   = 2'd3
  } state_e;
endpackage

// File: rtl/temp_average_divider_if.sv
// Request/result bundle between the sensor aggregation stage and the averaging divider.
interface temp_average_divider_if #(
  parameter int unsigned SUM_W = 16,
  parameter int unsigned CNT_W = 8
);
  logic             start_i;
  logic [SUM_W-1:0] temp_sum_i;
  logic [CNT_W-1:0] nr_active_sensors_i;
  logic             busy_o;
  logic             valid_o;
  logic [7:0]       temp_avg_o;
  logic             overflow_o;
  logic             div_by_zero_o;
  logic             alert_low_o;
  logic             alert_high_o;

  modport master (
    output start_i, temp_sum_i, nr_active_sensors_i,
    input  busy_o, valid_o, temp_avg_o, overflow_o, div_by_zero_o,
           alert_low_o, alert_high_o
  );

  modport slave (
    input  start_i, temp_sum_i, nr_active_sensors_i,
    output busy_o, valid_o, temp_avg_o, overflow_o, div_by_zero_o,
           alert_low_o, alert_high_o
  );
endinterface

// File: rtl/seq_divider_core.sv
// Radix-2 restoring divider: one quotient bit per step, operands captured on load.
module seq_divider_core
  import temp_monitor_pkg::*;
#(
  parameter int unsigned SUM_W = SUM_W_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [SUM_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic [SUM_W-1:0] quot_o,
  output logic [CNT_W:0]   rem_o,
  output logic [CNT_W-1:0] divisor_o,
  output logic             last_o
);
  localparam int unsigned IW = $clog2(SUM_W + 1);

  logic [SUM_W-1:0] quot_q;
  logic [CNT_W:0]   rem_q;
  logic [CNT_W-1:0] div_q;
  logic [IW-1:0]    iter_q;
  logic [CNT_W:0]   rem_sh;
  logic [CNT_W+1:0] diff;

  // rem stays below the divisor, so its top bit is free to take the shifted-in quotient MSB
  always_comb begin
    rem_sh = {rem_q[CNT_W-1:0], quot_q[SUM_W-1]};
    diff   = {1'b0, rem_sh} - {2'b00, div_q};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      quot_q <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      iter_q <= '0;
    end else if (load_i) begin
      quot_q <= dividend_i;
      rem_q  <= '0;
      div_q  <= divisor_i;
      iter_q <= '0;
    end else if (step_i) begin
      iter_q <= iter_q + 1'b1;
      if (diff[CNT_W+1]) begin
        rem_q  <= rem_sh;
        quot_q <= {quot_q[SUM_W-2:0], 1'b0};
      end else begin
        rem_q  <= diff[CNT_W:0];
        quot_q <= {quot_q[SUM_W-2:0], 1'b1};
      end
    end
  end

  always_comb begin
    quot_o    = quot_q;
    rem_o     = rem_q;
    divisor_o = div_q;
    last_o    = (iter_q == IW'(SUM_W - 1));
  end
endmodule

// File: rtl/temp_average_divider.sv
// Rounded average temperature with saturation and low/high threshold classification.
module temp_average_divider
  import temp_monitor_pkg::*;
#(
  parameter int unsigned SUM_W     = SUM_W_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF,
  parameter int unsigned TEMP_LOW  = TEMP_LOW_DEF,
  parameter int unsigned TEMP_HIGH = TEMP_HIGH_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  temp_average_divider_if.slave bus
);
  localparam logic [7:0] LOW8  = 8'(TEMP_LOW);
  localparam logic [7:0] HIGH8 = 8'(TEMP_HIGH);

  state_e           state_q, state_d;
  logic             accept, load, step;
  logic             dz_q;
  logic [SUM_W:0]   q_q, q_d;
  logic             round_up;
  logic             over;
  logic [7:0]       avg_sat;
  logic [SUM_W-1:0] quot;
  logic [CNT_W:0]   rem;
  logic [CNT_W-1:0] divisor;
  logic             last;

  seq_divider_core #(
    .SUM_W (SUM_W),
    .CNT_W (CNT_W)
  ) u_core (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (bus.temp_sum_i),
    .divisor_i  (bus.nr_active_sensors_i),
    .quot_o     (quot),
    .rem_o      (rem),
    .divisor_o  (divisor),
    .last_o     (last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // The valid cycle is already IDLE, so a start coinciding with it must be masked here
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.valid_o) begin
          accept = 1'b1;
          if (bus.nr_active_sensors_i == '0) begin
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = DIVIDE;
          end
        end
      end
      DIVIDE: begin
        step = 1'b1;
        if (last) state_d = ROUND;
      end
      ROUND:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    bus.busy_o = (state_q != IDLE);
  end

  always_comb begin
    round_up = ({rem, 1'b0} >= {2'b00, divisor});
    q_d      = {1'b0, quot} + (SUM_W + 1)'(round_up);
    over     = |q_q[SUM_W:8];
    avg_sat  = over ? AVG_MAX : q_q[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dz_q              <= 1'b0;
      q_q               <= '0;
      bus.valid_o       <= 1'b0;
      bus.temp_avg_o    <= '0;
      bus.overflow_o    <= 1'b0;
      bus.div_by_zero_o <= 1'b0;
      bus.alert_low_o   <= 1'b0;
      bus.alert_high_o  <= 1'b0;
    end else begin
      bus.valid_o <= 1'b0;
      if (accept) dz_q <= (bus.nr_active_sensors_i == '0);
      if (state_q == ROUND) q_q <= q_d;
      if (state_q == DONE) begin
        bus.valid_o <= 1'b1;
        if (dz_q) begin
          bus.temp_avg_o    <= '0;
          bus.overflow_o    <= 1'b0;
          bus.div_by_zero_o <= 1'b1;
          bus.alert_low_o   <= 1'b0;
          bus.alert_high_o  <= 1'b0;
        end else begin
          bus.temp_avg_o    <= avg_sat;
          bus.overflow_o    <= over;
          bus.div_by_zero_o <= 1'b0;
          bus.alert_low_o   <= (avg_sat < LOW8);
          bus.alert_high_o  <= (avg_sat > HIGH8);
        end
      end
    end
  end
endmodule

// File: tb/tb_temp_average_divider.sv
// Randomized self-checking bench for temp_average_divider against an arithmetic reference.
module tb_temp_average_divider;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  temp_average_divider_if #(.SUM_W(16), .CNT_W(8)) bus ();

  temp_average_divider #(
    .SUM_W     (16),
    .CNT_W     (8),
    .TEMP_LOW  (19),
    .TEMP_HIGH (26)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Round-half-up average from the textbook identity floor((2s+c)/(2c))
  task automatic model(input int s, input int c, output int avg, output int ovf,
                       output int dz, output int lo, output int hi);
    int q;
    if (c == 0) begin
      avg = 0; ovf = 0; dz = 1; lo = 0; hi = 0;
    end else begin
      q   = (2 * s + c) / (2 * c);
      ovf = (q > 255) ? 1 : 0;
      avg = ovf ? 255 : q;
      dz  = 0;
      lo  = (avg < 19) ? 1 : 0;
      hi  = (avg > 26) ? 1 : 0;
    end
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!bus.valid_o && lat < limit);
    if (!bus.valid_o) lat = -1;
  endtask

  task automatic check_result(input int s, input int c);
    int avg, ovf, dz, lo, hi;
    model(s, c, avg, ovf, dz, lo, hi);
    check("avg",      32'(bus.temp_avg_o),    avg);
    check("overflow", 32'(bus.overflow_o),    ovf);
    check("div_zero", 32'(bus.div_by_zero_o), dz);
    check("alert_lo", 32'(bus.alert_low_o),   lo);
    check("alert_hi", 32'(bus.alert_high_o),  hi);
  endtask

  task automatic run_op(input int s, input int c);
    int lat;
    bus.start_i             = 1'b1;
    bus.temp_sum_i          = 16'(s);
    bus.nr_active_sensors_i = 8'(c);
    cycle();
    bus.start_i             = 1'b0;
    bus.temp_sum_i          = 16'($urandom);
    bus.nr_active_sensors_i = 8'($urandom);
    check("busy_after_start", 32'(bus.busy_o), 1);
    wait_valid(40, lat);
    check("latency", lat, (c == 0) ? 1 : 18);
    check("busy_at_valid", 32'(bus.busy_o), 0);
    check_result(s, c);
    cycle();
    check("valid_one_cycle", 32'(bus.valid_o), 0);
    check_result(s, c);
  endtask

  initial begin
    int lat, nvalid, s, c;
    bus.start_i             = 1'b0;
    bus.temp_sum_i          = '0;
    bus.nr_active_sensors_i = '0;
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    check("rst_valid", 32'(bus.valid_o),       0);
    check("rst_busy",  32'(bus.busy_o),        0);
    check("rst_avg",   32'(bus.temp_avg_o),    0);
    check("rst_ovf",   32'(bus.overflow_o),    0);
    check("rst_dz",    32'(bus.div_by_zero_o), 0);
    check("rst_lo",    32'(bus.alert_low_o),   0);
    check("rst_hi",    32'(bus.alert_high_o),  0);

    run_op(150, 6);
    run_op(155, 6);
    run_op(61, 2);
    run_op(36, 2);
    run_op(100, 0);
    run_op(1000, 2);
    run_op(511, 2);
    run_op(0, 1);
    run_op(65535, 1);
    run_op(65535, 255);

    // Second start while busy is dropped, not queued
    bus.start_i = 1'b1; bus.temp_sum_i = 16'd150; bus.nr_active_sensors_i = 8'd6;
    cycle();
    bus.start_i = 1'b0;
    repeat (4) cycle();
    bus.start_i = 1'b1; bus.temp_sum_i = 16'd20; bus.nr_active_sensors_i = 8'd1;
    cycle();
    bus.start_i = 1'b0;
    wait_valid(40, lat);
    check("hs_latency", lat, 13);
    check_result(150, 6);
    nvalid = 0;
    repeat (25) begin
      cycle();
      if (bus.valid_o) nvalid++;
    end
    check("hs_single_valid", nvalid, 0);

    // Start held across the valid cycle: ignored there, accepted one cycle later
    bus.start_i = 1'b1; bus.temp_sum_i = 16'd150; bus.nr_active_sensors_i = 8'd6;
    cycle();
    bus.start_i = 1'b0;
    wait_valid(40, lat);
    check("b2b_first_latency", lat, 18);
    bus.start_i = 1'b1; bus.temp_sum_i = 16'd20; bus.nr_active_sensors_i = 8'd1;
    cycle();
    check("b2b_ignored_in_valid", 32'(bus.busy_o), 0);
    cycle();
    bus.start_i = 1'b0;
    check("b2b_accepted", 32'(bus.busy_o), 1);
    wait_valid(40, lat);
    check("b2b_latency", lat, 18);
    check_result(20, 1);
    cycle();

    // Reset mid-division
    bus.start_i = 1'b1; bus.temp_sum_i = 16'd155; bus.nr_active_sensors_i = 8'd6;
    cycle();
    bus.start_i = 1'b0;
    repeat (5) cycle();
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    check("mid_rst_busy", 32'(bus.busy_o),       0);
    check("mid_rst_avg",  32'(bus.temp_avg_o),   0);
    check("mid_rst_dz",   32'(bus.div_by_zero_o), 0);
    check("mid_rst_lo",   32'(bus.alert_low_o),  0);
    nvalid = 0;
    repeat (25) begin
      cycle();
      if (bus.valid_o) nvalid++;
    end
    check("mid_rst_no_valid", nvalid, 0);
    run_op(155, 6);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 0;
        1:       c = $urandom_range(1, 4);
        default: c = $urandom_range(1, 255);
      endcase
      s = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 65535) : c * $urandom_range(15, 30);
      if (s > 65535) s = 65535;
      run_op(s, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
